axi_lite_reg_bridge: RTL and testbench

- AXI4-lite slave front end that turns bus transactions into single-cycle register request pulses (wreq/waddr/wdata, rreq/raddr) and returns ack/data.
- Sits directly upstream of every block register map (PSS detector, SSS detector, FFT control) and feeds its request/ack port.
- Write and read channels are independent and may be in flight at the same time.

---
 rtl/axi_lite_reg_bridge.sv | 222 ++++++++++++++++++++++
 tb/tb_axi_lite_reg_bridge.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_reg_bridge.sv
// AXI4-lite slave that converts bus transactions into single-cycle register request pulses.
// Optional define ACK_TIMEOUT_EN: bounded wait for wack/rack, SLVERR response on expiry.
module axi_lite_reg_bridge #(
    parameter int ADDRESS_WIDTH  = 11,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic [ADDRESS_WIDTH-1:0] s_axi_awaddr,
    input  logic                     s_axi_awvalid,
    output logic                     s_axi_awready,
    input  logic [31:0]              s_axi_wdata,
    input  logic [3:0]               s_axi_wstrb,
    input  logic                     s_axi_wvalid,
    output logic                     s_axi_wready,
    output logic [1:0]               s_axi_bresp,
    output logic                     s_axi_bvalid,
    input  logic                     s_axi_bready,
    input  logic [ADDRESS_WIDTH-1:0] s_axi_araddr,
    input  logic                     s_axi_arvalid,
    output logic                     s_axi_arready,
    output logic [31:0]              s_axi_rdata,
    output logic [1:0]               s_axi_rresp,
    output logic                     s_axi_rvalid,
    input  logic                     s_axi_rready,
    output logic                     wreq_o,
    output logic [ADDRESS_WIDTH-3:0] waddr_o,
    output logic [31:0]              wdata_o,
    input  logic                     wack,
    output logic                     rreq_o,
    output logic [ADDRESS_WIDTH-3:0] raddr_o,
    input  logic [31:0]              rdata,
    input  logic                     rack
);
    localparam int WA    = ADDRESS_WIDTH - 2;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {W_IDLE, W_REQ, W_WAIT, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT, R_RESP} r_state_t;

    w_state_t        w_state_q, w_state_d;
    r_state_t        r_state_q, r_state_d;
    logic            awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
    logic            wreq_q, wreq_d, rreq_q, rreq_d;
    logic            bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]      bresp_q, bresp_d, rresp_q, rresp_d;
    logic [WA-1:0]   waddr_q, waddr_d, raddr_q, raddr_d;
    logic [31:0]     wdata_q, wdata_d, rdata_q, rdata_d;
    logic            aw_have, w_have;
    logic [CNT_W-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;

    // Byte lanes and the byte offset carry no information for full-word registers.
    logic unused_bits;
    assign unused_bits = ^{s_axi_wstrb, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // Write channel: AW and W are latched independently; a dropped ready marks "held".
    always_comb begin
        w_state_d = w_state_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        wreq_d    = 1'b0;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        wcnt_d    = wcnt_q;
        aw_have   = !awready_q || s_axi_awvalid;
        w_have    = !wready_q || s_axi_wvalid;
        case (w_state_q)
            W_IDLE: begin
                if (s_axi_awvalid && awready_q) begin
                    waddr_d   = s_axi_awaddr[ADDRESS_WIDTH-1:2];
                    awready_d = 1'b0;
                end
                if (s_axi_wvalid && wready_q) begin
                    wdata_d  = s_axi_wdata;
                    wready_d = 1'b0;
                end
                if (aw_have && w_have) begin
                    w_state_d = W_REQ;
                    wreq_d    = 1'b1;
                end
            end
            W_REQ: begin
                w_state_d = W_WAIT;
                wcnt_d    = '0;
            end
            W_WAIT: begin
                if (wack) begin
                    w_state_d = W_RESP;
                    bvalid_d  = 1'b1;
                    bresp_d   = 2'b00;
                end
`ifdef ACK_TIMEOUT_EN
                else if (wcnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    w_state_d = W_RESP;
                    bvalid_d  = 1'b1;
                    bresp_d   = 2'b10;
                end else begin
                    wcnt_d = wcnt_q + CNT_W'(1);
                end
`endif
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    w_state_d = W_IDLE;
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read channel: address accepted only while idle.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rreq_d    = 1'b0;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        raddr_d   = raddr_q;
        rdata_d   = rdata_q;
        rcnt_d    = rcnt_q;
        case (r_state_q)
            R_IDLE: begin
                if (s_axi_arvalid && arready_q) begin
                    raddr_d   = s_axi_araddr[ADDRESS_WIDTH-1:2];
                    arready_d = 1'b0;
                    rreq_d    = 1'b1;
                    r_state_d = R_REQ;
                end
            end
            R_REQ: begin
                r_state_d = R_WAIT;
                rcnt_d    = '0;
            end
            R_WAIT: begin
                if (rack) begin
                    r_state_d = R_RESP;
                    rvalid_d  = 1'b1;
                    rresp_d   = 2'b00;
                    rdata_d   = rdata;
                end
`ifdef ACK_TIMEOUT_EN
                else if (rcnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    r_state_d = R_RESP;
                    rvalid_d  = 1'b1;
                    rresp_d   = 2'b10;
                    rdata_d   = 32'hDEADDEAD;
                end else begin
                    rcnt_d = rcnt_q + CNT_W'(1);
                end
`endif
            end
            R_RESP: begin
                if (s_axi_rready) begin
                    r_state_d = R_IDLE;
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            arready_q <= 1'b1;
            wreq_q    <= 1'b0;
            rreq_q    <= 1'b0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rresp_q   <= 2'b00;
            waddr_q   <= '0;
            raddr_q   <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            wcnt_q    <= '0;
            rcnt_q    <= '0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            arready_q <= arready_d;
            wreq_q    <= wreq_d;
            rreq_q    <= rreq_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
            waddr_q   <= waddr_d;
            raddr_q   <= raddr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            wcnt_q    <= wcnt_d;
            rcnt_q    <= rcnt_d;
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_arready = arready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;
    assign wreq_o        = wreq_q;
    assign rreq_o        = rreq_q;
    assign waddr_o       = waddr_q;
    assign raddr_o       = raddr_q;
    assign wdata_o       = wdata_q;

endmodule

// File: tb/tb_axi_lite_reg_bridge.sv
// Scoreboard bench for axi_lite_reg_bridge: request pulses and responses are checked against queued expectations.
module tb_axi_lite_reg_bridge;
    logic        clk = 1'b0;
    logic        reset_ni;
    logic [10:0] s_axi_awaddr, s_axi_araddr;
    logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
    logic [31:0] s_axi_wdata, s_axi_rdata, wdata_o, rdata;
    logic [3:0]  s_axi_wstrb;
    logic [1:0]  s_axi_bresp, s_axi_rresp;
    logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
    logic        s_axi_rvalid, s_axi_rready, wreq_o, rreq_o, wack, rack;
    logic [8:0]  waddr_o, raddr_o;

    int vectors = 0;
    int miscompares = 0;
    int wreq_cnt = 0;
    logic [8:0]  exp_waddr[$], exp_raddr[$];
    logic [31:0] exp_wdata[$], exp_rdata[$];
    logic [1:0]  exp_rresp[$];

    axi_lite_reg_bridge #(.ADDRESS_WIDTH(11), .TIMEOUT_CYCLES(64)) dut (
        .clk_i(clk), .reset_ni(reset_ni),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .wreq_o(wreq_o), .waddr_o(waddr_o), .wdata_o(wdata_o), .wack(wack),
        .rreq_o(rreq_o), .raddr_o(raddr_o), .rdata(rdata), .rack(rack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: pop expectations whenever the DUT emits a request or completes a read.
    always @(negedge clk) begin
        if (reset_ni && wreq_o) begin
            wreq_cnt++;
            vectors++;
            if (exp_waddr.size() == 0) begin
                miscompares++;
                $display("FAIL sb_wreq unexpected pulse addr %h", waddr_o);
            end else begin
                logic [8:0]  ea;
                logic [31:0] ed;
                ea = exp_waddr.pop_front();
                ed = exp_wdata.pop_front();
                if ({waddr_o, wdata_o} !== {ea, ed}) begin
                    miscompares++;
                    $display("FAIL sb_wreq got %h/%h exp %h/%h", waddr_o, wdata_o, ea, ed);
                end
            end
        end
        if (reset_ni && rreq_o) begin
            vectors++;
            if (exp_raddr.size() == 0) begin
                miscompares++;
                $display("FAIL sb_rreq unexpected pulse addr %h", raddr_o);
            end else begin
                logic [8:0] ra;
                ra = exp_raddr.pop_front();
                if (raddr_o !== ra) begin
                    miscompares++;
                    $display("FAIL sb_rreq got %h exp %h", raddr_o, ra);
                end
            end
        end
        if (reset_ni && s_axi_rvalid && s_axi_rready) begin
            vectors++;
            if (exp_rdata.size() == 0) begin
                miscompares++;
                $display("FAIL sb_rresp unexpected data %h", s_axi_rdata);
            end else begin
                logic [31:0] rd;
                logic [1:0]  rr;
                rd = exp_rdata.pop_front();
                rr = exp_rresp.pop_front();
                if ({s_axi_rdata, s_axi_rresp} !== {rd, rr}) begin
                    miscompares++;
                    $display("FAIL sb_rresp got %h/%b exp %h/%b", s_axi_rdata, s_axi_rresp, rd, rr);
                end
            end
        end
    end

    task automatic test_reset();
        reset_ni = 1'b0;
        repeat (3) tick();
        vectors++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, wreq_o, rreq_o,
             s_axi_bresp, s_axi_rresp} !== 11'b111_0000_0000) begin
            miscompares++;
            $display("FAIL reset_ctrl got %b exp 11100000000", {s_axi_awready, s_axi_wready,
                     s_axi_arready, s_axi_bvalid, s_axi_rvalid, wreq_o, rreq_o, s_axi_bresp, s_axi_rresp});
        end
        vectors++;
        if ({s_axi_rdata, waddr_o, raddr_o, wdata_o} !== 82'd0) begin
            miscompares++;
            $display("FAIL reset_data got %h exp 0", {s_axi_rdata, waddr_o, raddr_o, wdata_o});
        end
        reset_ni = 1'b1;
        tick();
    endtask

    task automatic test_write_basic();
        int n0;
        n0 = wreq_cnt;
        s_axi_awaddr = 11'h02C; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'h5;    s_axi_wvalid = 1'b1;
        exp_waddr.push_back(9'h00B); exp_wdata.push_back(32'h5);
        vectors++;
        if ({s_axi_awready, s_axi_wready} !== 2'b11) begin
            miscompares++;
            $display("FAIL wr_ready_idle got %b exp 11", {s_axi_awready, s_axi_wready});
        end
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        vectors++;
        if ({wreq_o, s_axi_awready, s_axi_wready} !== 3'b100) begin
            miscompares++;
            $display("FAIL wr_t1 wreq/awready/wready got %b exp 100", {wreq_o, s_axi_awready, s_axi_wready});
        end
        tick();
        vectors++;
        if ({wreq_o, s_axi_bvalid} !== 2'b00) begin
            miscompares++;
            $display("FAIL wr_t2 wreq/bvalid got %b exp 00", {wreq_o, s_axi_bvalid});
        end
        wack = 1'b1;
        tick();
        wack = 1'b0;
        vectors++;
        if ({s_axi_bvalid, s_axi_bresp} !== 3'b100) begin
            miscompares++;
            $display("FAIL wr_t3 bvalid/bresp got %b exp 100", {s_axi_bvalid, s_axi_bresp});
        end
        tick();
        vectors++;
        if ({s_axi_bvalid, s_axi_awready, s_axi_wready} !== 3'b100) begin
            miscompares++;
            $display("FAIL wr_bhold got %b exp 100", {s_axi_bvalid, s_axi_awready, s_axi_wready});
        end
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        vectors++;
        if ({s_axi_bvalid, s_axi_awready, s_axi_wready} !== 3'b011) begin
            miscompares++;
            $display("FAIL wr_bdone got %b exp 011", {s_axi_bvalid, s_axi_awready, s_axi_wready});
        end
        vectors++;
        if (wreq_cnt - n0 !== 1) begin
            miscompares++;
            $display("FAIL wr_pulses got %0d exp 1", wreq_cnt - n0);
        end
    endtask

    task automatic test_w_first();
        int n0;
        n0 = wreq_cnt;
        s_axi_wdata = 32'hA5A5_1234; s_axi_wvalid = 1'b1;
        tick();
        s_axi_wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if ({s_axi_wready, s_axi_awready, wreq_o} !== 3'b010) begin
                miscompares++;
                $display("FAIL wfirst_wait%0d wready/awready/wreq got %b exp 010", i,
                         {s_axi_wready, s_axi_awready, wreq_o});
            end
            if (i < 2) tick();
        end
        s_axi_awaddr = 11'h040; s_axi_awvalid = 1'b1;
        exp_waddr.push_back(9'h010); exp_wdata.push_back(32'hA5A5_1234);
        tick();
        s_axi_awvalid = 1'b0;
        vectors++;
        if (wreq_o !== 1'b1) begin
            miscompares++;
            $display("FAIL wfirst_wreq got %b exp 1", wreq_o);
        end
        wack = 1'b1;
        tick();
        wack = 1'b0;
        tick();
        vectors++;
        if (s_axi_bvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL wack_in_req_ignored bvalid got %b exp 0", s_axi_bvalid);
        end
        wack = 1'b1;
        tick();
        wack = 1'b0;
        vectors++;
        if (s_axi_bvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL wfirst_bvalid got %b exp 1", s_axi_bvalid);
        end
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        vectors++;
        if (wreq_cnt - n0 !== 1) begin
            miscompares++;
            $display("FAIL wfirst_pulses got %0d exp 1", wreq_cnt - n0);
        end
    endtask

    task automatic test_read_backpressure();
        logic [31:0] held;
        s_axi_araddr = 11'h00C; s_axi_arvalid = 1'b1;
        exp_raddr.push_back(9'h003);
        exp_rdata.push_back(32'h5053_5344); exp_rresp.push_back(2'b00);
        vectors++;
        if (s_axi_arready !== 1'b1) begin
            miscompares++;
            $display("FAIL rd_arready_idle got %b exp 1", s_axi_arready);
        end
        tick();
        s_axi_arvalid = 1'b0;
        vectors++;
        if ({rreq_o, s_axi_arready} !== 2'b10) begin
            miscompares++;
            $display("FAIL rd_t1 rreq/arready got %b exp 10", {rreq_o, s_axi_arready});
        end
        tick();
        rack = 1'b1; rdata = 32'h5053_5344;
        tick();
        rack = 1'b0; rdata = 32'h0;
        held = s_axi_rdata;
        vectors++;
        if ({s_axi_rvalid, s_axi_rdata} !== {1'b1, 32'h5053_5344}) begin
            miscompares++;
            $display("FAIL rd_t3 rvalid/rdata got %b/%h exp 1/50535344", s_axi_rvalid, s_axi_rdata);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if ({s_axi_rvalid, s_axi_arready, s_axi_rdata} !== {2'b10, held}) begin
                miscompares++;
                $display("FAIL rd_hold%0d rvalid/arready/rdata got %b%b/%h exp 10/%h", i,
                         s_axi_rvalid, s_axi_arready, s_axi_rdata, held);
            end
        end
        s_axi_rready = 1'b1;
        tick();
        s_axi_rready = 1'b0;
        vectors++;
        if ({s_axi_rvalid, s_axi_arready} !== 2'b01) begin
            miscompares++;
            $display("FAIL rd_done rvalid/arready got %b exp 01", {s_axi_rvalid, s_axi_arready});
        end
    endtask

    task automatic test_concurrent();
        s_axi_awaddr = 11'h01C; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'h1122_3344; s_axi_wvalid = 1'b1;
        s_axi_araddr = 11'h018; s_axi_arvalid = 1'b1;
        exp_waddr.push_back(9'h007); exp_wdata.push_back(32'h1122_3344);
        exp_raddr.push_back(9'h006);
        exp_rdata.push_back(32'hCAFE_F00D); exp_rresp.push_back(2'b00);
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        vectors++;
        if ({wreq_o, rreq_o} !== 2'b11) begin
            miscompares++;
            $display("FAIL conc_req wreq/rreq got %b exp 11", {wreq_o, rreq_o});
        end
        tick();
        rack = 1'b1; rdata = 32'hCAFE_F00D;
        tick();
        rack = 1'b0; rdata = 32'h0;
        vectors++;
        if ({s_axi_rvalid, s_axi_bvalid} !== 2'b10) begin
            miscompares++;
            $display("FAIL conc_rfirst rvalid/bvalid got %b exp 10", {s_axi_rvalid, s_axi_bvalid});
        end
        wack = 1'b1; s_axi_rready = 1'b1; s_axi_bready = 1'b1;
        tick();
        wack = 1'b0; s_axi_rready = 1'b0;
        vectors++;
        if ({s_axi_rvalid, s_axi_bvalid} !== 2'b01) begin
            miscompares++;
            $display("FAIL conc_wlast rvalid/bvalid got %b exp 01", {s_axi_rvalid, s_axi_bvalid});
        end
        tick();
        s_axi_bready = 1'b0;
        vectors++;
        if ({s_axi_bvalid, s_axi_awready, s_axi_arready} !== 3'b011) begin
            miscompares++;
            $display("FAIL conc_idle got %b exp 011", {s_axi_bvalid, s_axi_awready, s_axi_arready});
        end
    endtask

    task automatic test_reset_mid_write();
        s_axi_awaddr = 11'h100; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'h0BAD_F00D; s_axi_wvalid = 1'b1;
        exp_waddr.push_back(9'h040); exp_wdata.push_back(32'h0BAD_F00D);
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        tick();
        reset_ni = 1'b0;
        tick();
        reset_ni = 1'b1;
        vectors++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, wreq_o, rreq_o,
             s_axi_bresp, s_axi_rresp} !== 11'b111_0000_0000) begin
            miscompares++;
            $display("FAIL midrst_ctrl got %b exp 11100000000", {s_axi_awready, s_axi_wready,
                     s_axi_arready, s_axi_bvalid, s_axi_rvalid, wreq_o, rreq_o, s_axi_bresp, s_axi_rresp});
        end
        vectors++;
        if ({s_axi_rdata, waddr_o, raddr_o, wdata_o} !== 82'd0) begin
            miscompares++;
            $display("FAIL midrst_data got %h exp 0", {s_axi_rdata, waddr_o, raddr_o, wdata_o});
        end
        wack = 1'b1; rack = 1'b1; rdata = 32'h1357_9BDF;
        tick();
        wack = 1'b0; rack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if ({s_axi_bvalid, s_axi_rvalid} !== 2'b00) begin
                miscompares++;
                $display("FAIL midrst_noresp%0d bvalid/rvalid got %b exp 00", i, {s_axi_bvalid, s_axi_rvalid});
            end
            tick();
        end
    endtask

`ifdef ACK_TIMEOUT_EN
    task automatic test_timeout();
        int k;
        s_axi_araddr = 11'h020; s_axi_arvalid = 1'b1;
        exp_raddr.push_back(9'h008);
        exp_rdata.push_back(32'hDEAD_DEAD); exp_rresp.push_back(2'b10);
        tick();
        s_axi_arvalid = 1'b0;
        k = 1;
        while (!s_axi_rvalid && k < 200) begin
            tick();
            k++;
        end
        vectors++;
        if (k !== 66) begin
            miscompares++;
            $display("FAIL tmo_latency cycles got %0d exp 66", k);
        end
        s_axi_rready = 1'b1;
        tick();
        s_axi_rready = 1'b0;
        rack = 1'b1;
        tick();
        rack = 1'b0;
        vectors++;
        if (s_axi_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL tmo_late_ack rvalid got %b exp 0", s_axi_rvalid);
        end
    endtask
`endif

    initial begin
        reset_ni = 1'b0;
        s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = 4'hF;
        s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0; wack = 1'b0; rack = 1'b0; rdata = '0;
        test_reset();
        test_write_basic();
        test_w_first();
        test_read_backpressure();
        test_concurrent();
        test_reset_mid_write();
`ifdef ACK_TIMEOUT_EN
        test_timeout();
`endif
        tick();
        vectors++;
        if (exp_waddr.size() + exp_raddr.size() + exp_rdata.size() !== 0) begin
            miscompares++;
            $display("FAIL sb_drain left %0d/%0d/%0d exp 0/0/0", exp_waddr.size(), exp_raddr.size(),
                     exp_rdata.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
